// File: rtl/sram_pattern_tester.sv
// SRAM self-test engine: fills a 2^SPAN_LOG2 span with a pattern, reads it back, reports errors.
// Define SRAMTEST_LFSR_EN to make mode 3 a 32-bit Galois LFSR pattern (otherwise mode 3 == mode 0).
module sram_pattern_tester #(
  parameter int unsigned AW        = 19,
  parameter int unsigned DW        = 16,
  parameter int unsigned SPAN_LOG2 = 19,
  parameter int unsigned WE_CYCLES = 1,
  parameter int unsigned RD_WAIT   = 1,
  parameter int unsigned ECW       = 16
) (
  input  logic           CLOCK_50,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [DW-1:0]  seed,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic           mem_we,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [ECW-1:0] err_count,
  output logic [AW-1:0]  first_err_addr
);

  localparam int unsigned IW   = SPAN_LOG2 + 1;
  localparam int unsigned CMAX = (WE_CYCLES > RD_WAIT + 1) ? WE_CYCLES : RD_WAIT + 1;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [IW-1:0] LAST    = IW'((64'd1 << SPAN_LOG2) - 64'd1);
  localparam logic [CW-1:0] WE_LAST = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SETUP, S_WR_STROBE, S_RD_WAIT, S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic [CW-1:0] cnt;
  logic [1:0]    mode_r;
  logic [DW-1:0] seed_r;
  logic [DW-1:0] start_word_c;
  logic [DW-1:0] next_word_c;
  logic [DW-1:0] expect_c;
  logic          mismatch_c;

  // Stateless patterns; mode 3 falls back to the additive pattern.
  function automatic logic [DW-1:0] pattern_base(input logic [IW-1:0] i,
                                                 input logic [1:0]    md,
                                                 input logic [DW-1:0] sd);
    logic [DW-1:0] sum;
    sum = DW'(i) + sd;
    case (md)
      2'd1:    return ~sum;
      2'd2:    return i[0] ? ~sd : sd;
      default: return sum;
    endcase
  endfunction

`ifdef SRAMTEST_LFSR_EN
  localparam logic [31:0] POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
  endfunction

  logic [31:0] lfsr;
  logic [31:0] lfsr_adv_c;
  logic [31:0] lfsr_init_c;
  logic [31:0] lfsr_reload_c;

  assign lfsr_adv_c    = lfsr_step(lfsr);
  assign lfsr_init_c   = 32'(seed) | 32'd1;
  assign lfsr_reload_c = 32'(seed_r) | 32'd1;
`endif

  assign idx_next = idx + IW'(1);

  always_comb begin
    start_word_c = pattern_base(IW'(0), mode, seed);
    next_word_c  = pattern_base(idx_next, mode_r, seed_r);
    expect_c     = pattern_base(idx, mode_r, seed_r);
`ifdef SRAMTEST_LFSR_EN
    if (mode == 2'd3)   start_word_c = lfsr_init_c[DW-1:0];
    if (mode_r == 2'd3) begin
      next_word_c = lfsr_adv_c[DW-1:0];
      expect_c    = lfsr[DW-1:0];
    end
`endif
  end

  assign mismatch_c = (mem_rdata != expect_c);

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      cnt            <= '0;
      mode_r         <= '0;
      seed_r         <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_we         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
`ifdef SRAMTEST_LFSR_EN
      lfsr           <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_r         <= mode;
            seed_r         <= seed;
            idx            <= '0;
            cnt            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            mem_addr       <= '0;
            mem_wdata      <= start_word_c;
            mem_we         <= 1'b0;
`ifdef SRAMTEST_LFSR_EN
            lfsr           <= lfsr_init_c;
`endif
            state          <= S_WR_SETUP;
          end
        end

        S_WR_SETUP: begin
          mem_we <= 1'b1;
          cnt    <= '0;
          state  <= S_WR_STROBE;
        end

        S_WR_STROBE: begin
          if (cnt == WE_LAST) begin
            mem_we <= 1'b0;
            cnt    <= '0;
            if (idx == LAST) begin
              // Restart index and generator so the read phase regenerates the same sequence.
              idx      <= '0;
              mem_addr <= '0;
`ifdef SRAMTEST_LFSR_EN
              lfsr     <= lfsr_reload_c;
`endif
              state    <= S_RD_WAIT;
            end else begin
              idx       <= idx_next;
              mem_addr  <= AW'(idx_next);
              mem_wdata <= next_word_c;
`ifdef SRAMTEST_LFSR_EN
              lfsr      <= lfsr_adv_c;
`endif
              state     <= S_WR_SETUP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_RD_WAIT: begin
          if (cnt == RD_LAST) begin
            cnt <= '0;
            if (mismatch_c) begin
              if (err_count != '1) err_count <= err_count + ECW'(1);
              if (err_count == '0) first_err_addr <= AW'(idx);
            end
            if (idx == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch_c;
              state <= S_DONE;
            end else begin
              idx      <= idx_next;
              mem_addr <= AW'(idx_next);
`ifdef SRAMTEST_LFSR_EN
              lfsr     <= lfsr_adv_c;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Bench for sram_pattern_tester: behavioural SRAM with stuck-bit faults and a pattern reference model.
module tb_sram_pattern_tester;

  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 16;
  localparam int unsigned N   = 16;
  localparam int unsigned WEC = 1;
  localparam int unsigned RDW = 1;
  localparam int unsigned ECW = 4;
  localparam int          BUSY_CYCLES = N * (1 + WEC) + N * (RDW + 1);

  logic           CLOCK_50 = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     mode;
  logic [DW-1:0]  seed;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic           mem_we;
  logic           busy;
  logic           done;
  logic           pass;
  logic [ECW-1:0] err_count;
  logic [AW-1:0]  first_err_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  sram_pattern_tester #(
    .AW(AW), .DW(DW), .SPAN_LOG2(4), .WE_CYCLES(WEC), .RD_WAIT(RDW), .ECW(ECW)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  // SRAM model with per-address stuck-at masks on the read path.
  logic [DW-1:0] mem   [N];
  logic [DW-1:0] and_m [N];
  logic [DW-1:0] or_m  [N];

  assign mem_rdata = (mem[mem_addr[3:0]] & and_m[mem_addr[3:0]]) | or_m[mem_addr[3:0]];

  always @(posedge CLOCK_50) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;

  // Monitor: busy cycles and a log of every completed write strobe.
  int            busy_cnt = 0;
  int            unstable = 0;
  int            wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  int            wr_len_q  [$];
  bit            we_prev = 1'b0;
  int            cur_len = 0;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;

  always @(negedge CLOCK_50) begin
    if (busy) busy_cnt++;
    if (mem_we) begin
      if (!we_prev) begin
        cur_len  = 0;
        cur_addr = mem_addr;
        cur_data = mem_wdata;
      end else if (mem_addr != cur_addr || mem_wdata != cur_data) begin
        unstable++;
      end
      cur_len++;
    end else if (we_prev) begin
      wr_addr_q.push_back(int'(cur_addr));
      wr_data_q.push_back(cur_data);
      wr_len_q.push_back(cur_len);
    end
    we_prev = mem_we;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pattern; the LFSR word is rebuilt from the seed by stepping i times.
  function automatic logic [DW-1:0] ref_pat(input int md, input logic [DW-1:0] sd, input int i);
    case (md)
      1: return ~(DW'(i) + sd);
      2: return (i % 2 == 1) ? ~sd : sd;
`ifdef SRAMTEST_LFSR_EN
      3: begin
        logic [31:0] l;
        l = 32'(sd) | 32'd1;
        for (int k = 0; k < i; k++) l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        return l[DW-1:0];
      end
`endif
      default: return DW'(i) + sd;
    endcase
  endfunction

  task automatic clear_faults();
    for (int k = 0; k < N; k++) begin
      and_m[k] = '1;
      or_m[k]  = '0;
    end
  endtask

  task automatic run_test(input string name, input int md, input logic [DW-1:0] sd,
                          input bit poke_start);
    int            errs = 0;
    int            first = 0;
    bit            seen = 1'b0;
    int            busy_base;
    int            wr_base;
    int            unst_base;
    int            nwr;
    logic [DW-1:0] e;
    logic [DW-1:0] rd;

    for (int k = 0; k < N; k++) begin
      e  = ref_pat(md, sd, k);
      rd = (e & and_m[k]) | or_m[k];
      if (rd != e) begin
        if (!seen) first = k;
        seen = 1'b1;
        if (errs < (1 << ECW) - 1) errs++;
      end
    end

    @(negedge CLOCK_50);
    busy_base = busy_cnt;
    wr_base   = wr_addr_q.size();
    unst_base = unstable;
    mode  = 2'(md);
    seed  = sd;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    check({name, ".busy_on"}, 64'(busy), 64'd1);
    check({name, ".done_clr"}, 64'(done), 64'd0);

    for (int c = 0; c < 300 && done !== 1'b1; c++) begin
      @(negedge CLOCK_50);
      start = (poke_start && c >= 8 && c < 11) ? 1'b1 : 1'b0;
    end
    start = 1'b0;

    check({name, ".done"}, 64'(done), 64'd1);
    check({name, ".busy_cycles"}, 64'(busy_cnt - busy_base), 64'(BUSY_CYCLES));
    nwr = wr_addr_q.size() - wr_base;
    check({name, ".n_writes"}, 64'(nwr), 64'(N));
    for (int k = 0; k < N && k < nwr; k++) begin
      check($sformatf("%s.wr_addr%0d", name, k), 64'(wr_addr_q[wr_base + k]), 64'(k));
      check($sformatf("%s.wr_data%0d", name, k), 64'(wr_data_q[wr_base + k]), 64'(ref_pat(md, sd, k)));
      check($sformatf("%s.we_len%0d", name, k), 64'(wr_len_q[wr_base + k]), 64'(WEC));
    end
    check({name, ".stable"}, 64'(unstable - unst_base), 64'd0);
    check({name, ".busy_off"}, 64'(busy), 64'd0);
    check({name, ".pass"}, 64'(pass), 64'(errs == 0));
    check({name, ".err_count"}, 64'(err_count), 64'(errs));
    check({name, ".first_err"}, 64'(first_err_addr), 64'(first));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit found;
    rst   = 1'b1;
    start = 1'b0;
    mode  = '0;
    seed  = '0;
    clear_faults();
    for (int k = 0; k < N; k++) mem[k] = '0;
    repeat (3) @(negedge CLOCK_50);
    check("rst.mem_we", 64'(mem_we), 64'd0);
    check("rst.mem_addr", 64'(mem_addr), 64'd0);
    check("rst.mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.pass", 64'(pass), 64'd0);
    check("rst.err_count", 64'(err_count), 64'd0);
    check("rst.first_err", 64'(first_err_addr), 64'd0);
    rst = 1'b0;

    run_test("m0_seed0", 0, 16'h0000, 1'b0);

    or_m[5] = 16'h0008;
    run_test("stuck_b3_a5", 0, 16'h0000, 1'b0);
    check("stuck_b3_a5.first5", 64'(first_err_addr), 64'd5);
    clear_faults();

    run_test("m2_checker", 2, 16'h5555, 1'b1);
    for (int k = 0; k < N; k++)
      check($sformatf("m2_checker.mem%0d", k), 64'(mem[k]), (k % 2 == 1) ? 64'hAAAA : 64'h5555);

    for (int k = 0; k < N; k++) and_m[k] = '0;
    run_test("all_stuck0_m1", 1, 16'h0000, 1'b0);
    check("all_stuck0_m1.sat", 64'(err_count), 64'd15);
    clear_faults();

    // Reset in the middle of the write strobe for address 7.
    @(negedge CLOCK_50);
    mode  = 2'd0;
    seed  = '0;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (mem_we && mem_addr == AW'(7)) found = 1'b1;
      else @(negedge CLOCK_50);
    end
    check("rst_mid.found_we7", 64'(found), 64'd1);
    rst = 1'b1;
    @(negedge CLOCK_50);
    check("rst_mid.mem_we", 64'(mem_we), 64'd0);
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    run_test("after_rst", 0, 16'h0000, 1'b0);

    run_test("m3_seed1", 3, 16'h0001, 1'b0);
`ifndef SRAMTEST_LFSR_EN
    for (int k = 0; k < N; k++)
      check($sformatf("m3_as_m0.mem%0d", k), 64'(mem[k]), 64'(k + 1));
`endif

    for (int r = 0; r < 5; r++) begin
      int            md;
      logic [DW-1:0] sd;
      int            a;
      md = int'($urandom_range(0, 3));
      sd = DW'($urandom);
      clear_faults();
      if ($urandom_range(0, 1) == 1) begin
        a        = int'($urandom_range(0, N - 1));
        or_m[a]  = DW'($urandom);
        and_m[a] = DW'($urandom);
      end
      run_test($sformatf("rand%0d_m%0d", r, md), md, sd, r == 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_pattern_tester.md
Name: sram_pattern_tester

Overview:
Parametrised self-test engine for the external asynchronous static RAM on the expansion headers. It writes a selectable data pattern over a configurable address span, then reads the span back. Each read is compared against the regenerated pattern, and the engine reports pass/fail, an error count and the first failing address. It drives the existing sram request interface (address, write data, read data, write enable) and replaces the hard-coded fill-then-slow-readback sequencer.

Parameters:
AW, 19, address width of the SRAM request interface
DW, 16, data width (1..32)
SPAN_LOG2, 19, log2 of tested span; tests addresses 0..2^SPAN_LOG2-1; must be <= AW
WE_CYCLES, 1, cycles mem_we is held high per write (>=1)
RD_WAIT, 1, cycles the address is held before the read sample (>=1)
ECW, 16, error counter width

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  level; sampled in IDLE/DONE to begin a test
mode  in  2  pattern select, latched at start
seed  in  DW  pattern seed, latched at start
mem_addr  out  AW  SRAM address
mem_wdata  out  DW  SRAM write data
mem_rdata  in  DW  SRAM read data
mem_we  out  1  write strobe, active high
busy  out  1  high while writing or reading
done  out  1  high from test completion until next start
pass  out  1  valid when done; 1 iff err_count==0
err_count  out  ECW  mismatches, saturating
first_err_addr  out  AW  address of first mismatch; 0 if none

Behaviour:
- Reset (synchronous, any state): state=IDLE; mem_we=0; mem_addr=0; mem_wdata=0; busy=0; done=0; pass=0; err_count=0; first_err_addr=0. A reset during a write drops mem_we on that same edge.
- States: IDLE, WR_SETUP, WR_STROBE, RD_WAIT, DONE.
- IDLE/DONE + start=1 at an edge:
  - latch mode and seed; index i=0
  - clear err_count, first_err_addr, done and pass
  - enter WR_SETUP; busy=1 from that edge
- start is ignored while busy.
- WR_SETUP (1 cycle): mem_addr=i, mem_wdata=P(i), mem_we=0 → WR_STROBE.
- WR_STROBE (WE_CYCLES cycles): mem_we=1, address and data held stable. On the last cycle's edge, mem_we=0.
  - If i==N-1 (N=2^SPAN_LOG2): i=0, pattern generator reset → RD_WAIT.
  - Else: i=i+1 → WR_SETUP.
- Write cost per word = 1+WE_CYCLES cycles.
- RD_WAIT: mem_addr=i, mem_we=0. Held for RD_WAIT+1 cycles; mem_rdata is sampled on the edge ending the final cycle.
- On mismatch with P(i):
  - err_count increments, saturating at all-ones.
  - If this is the first mismatch, first_err_addr=i.
- After the sample: if i==N-1 → DONE, else i=i+1 and stay in RD_WAIT (new address).
- DONE: busy=0, done=1, pass=(err_count==0). Outputs hold until start or rst.
- Total busy cycles = N*(1+WE_CYCLES) + N*(RD_WAIT+1).
- Pattern P(i), i zero-extended/truncated to DW:
  - mode 0: i + seed, mod 2^DW
  - mode 1: ~(i + seed)
  - mode 2: checkerboard; seed when i[0]==0, ~seed when i[0]==1
  - mode 3: see Optional Feature
- Index counter is SPAN_LOG2+1 bits; the terminal compare uses N-1, so there is no wrap into address N.
- The read phase regenerates P(i) identically to the write phase (stateful generators are re-seeded at the read start).

Optional Feature:
- Macro: SRAMTEST_LFSR_EN.
- Defined: mode 3 uses a 32-bit Galois LFSR, polynomial 0x80200003.
  - Loaded with {seed} | 1 (never zero) at write start and again at read start.
  - Advances once per address.
  - P(i) = lfsr[DW-1:0].
- Not defined: mode 3 behaves exactly as mode 0; no LFSR logic is synthesised.

Test Plan:
- Test setup for all scenarios:
  - SPAN_LOG2=4, WE_CYCLES=1, RD_WAIT=1, DW=16, ECW=4
  - behavioural SRAM model
- Mode 0, seed 0x0000, start pulse:
  - writes 0x0000..0x000F to addresses 0..15, each with mem_we high for exactly 1 cycle
  - busy for 64 cycles
  - done=1, pass=1, err_count=0
- Model bit 3 stuck-at-1 at address 5, mode 0, seed 0 → err_count=1, first_err_addr=5, pass=0.
- Mode 2, seed 0x5555:
  - even addresses hold 0x5555, odd addresses hold 0xAAAA
  - pass=1
  - a second start during busy is ignored (cycle count unchanged)
- Model with all data bits stuck at 0, mode 1, seed 0 → err_count saturates at 15, first_err_addr=0.
- rst asserted while mem_we=1 at address 7:
  - the next cycle shows mem_we=0, busy=0, done=0, err_count=0
  - a fresh start then completes with pass=1
- With SRAMTEST_LFSR_EN defined, mode 3, seed 0x0001:
  - written and read sequences match the reference LFSR, pass=1
- Without SRAMTEST_LFSR_EN, mode 3, seed 0x0001: data written equals mode 0 data (0x0001..0x0010).
